timer_multi_ch: RTL and testbench
=================================

Name: timer_multi_ch

Overview:
Memory-mapped timer device for the simple system bus, replacing the single-comparator timer.
- One shared 64-bit mtime counter, advanced by a programmable prescaler.
- NrChannels independent 64-bit comparators, each in one-shot or periodic (auto-reload) mode.
- Per-channel interrupt state/enable, per-channel interrupt outputs and an OR'd interrupt for the core's irq_timer_i.
- Occupies a 1 kB device window; decodes addr[9:2] only.

Parameters:
NrChannels, 4, number of compare channels (1..16)
DataWidth, 32, bus data width (fixed 32; other values unsupported)
AddressWidth, 32, bus address width
PrescaleWidth, 12, width of prescaler reload register and counter

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; synchronous, active-low
timer_req_i  input  1  bus request; single-cycle, always accepted
timer_we_i  input  1  write enable
timer_be_i  input  4  byte enables; writes honoured per byte
timer_addr_i  input  AddressWidth  byte address; bits [9:2] decoded
timer_wdata_i  input  32  write data
timer_rvalid_o  output  1  response valid, one cycle after req
timer_rdata_o  output  32  read data, valid with rvalid
timer_err_o  output  1  error response, valid with rvalid
timer_intr_o  output  NrChannels  per-channel interrupt = INTR_STATE & INTR_ENABLE
timer_intr_any_o  output  1  OR of timer_intr_o

Behaviour:
- Reset values (sync, rst_ni low at clk edge): all registers 0; all outputs 0; prescaler counter 0. Reset mid-transaction drops the pending response; no rvalid follows.
- Register map (byte offsets):
  - 0x000 CTRL: [0] global enable.
  - 0x004 PRESCALE: [PrescaleWidth-1:0].
  - 0x008 MTIME_LO; 0x00C MTIME_HI.
  - 0x010 INTR_STATE: W1C.
  - 0x014 INTR_ENABLE.
  - Channel n at 0x100+0x10*n: +0x0 CMP_LO, +0x4 CMP_HI, +0x8 CH_CTRL ([0] en, [1] periodic), +0xC PERIOD (32-bit).
- Bus response:
  - rvalid asserted exactly one cycle after every req (read or write).
  - err=1 for unmapped offsets and for channel index >= NrChannels; writes then have no effect and rdata=0.
  - Reads of unused register bits return 0.
- Prescaler: when CTRL.en=1, the counter increments each cycle. When counter==PRESCALE it clears and emits a tick. tick increments mtime by 1 with 64-bit wrap (0xFFFF_FFFF_FFFF_FFFF -> 0). PRESCALE=0 gives a tick every cycle.
- CTRL.en=0 freezes the counter and mtime; the counter value is retained.
- Writing PRESCALE clears the prescaler counter.
- A bus write to MTIME_LO/HI wins over a tick in the same cycle; the written half takes the new value and the other half is unchanged (no carry).
- Match for channel n: CH_CTRL.en && (mtime >= CMP), compared unsigned over 64 bits on registered values. Match evaluation is independent of CTRL.en.
- On a match, INTR_STATE[n] is set the next cycle. In addition:
  - one-shot: CH_CTRL.en cleared in the same update.
  - periodic: CMP += zero-extended PERIOD (64-bit, wraps); en stays set.
  - PERIOD=0 in periodic mode re-matches every cycle; legal.
- Simultaneous bus write and hardware update to the same register: hardware set of INTR_STATE beats W1C; bus write to CMP/CH_CTRL beats the hardware reload/clear.
- Several channels may match in one cycle; each updates independently.
- Outputs timer_intr_o/any_o are registered from INTR_STATE/INTR_ENABLE; 1-cycle latency from a state/enable change.

Test Plan:
- Reset with traffic: assert rst_ni=0 while a read is pending -> no rvalid; all regs read 0 afterwards; timer_intr_o=0.
- Prescaler rate: PRESCALE=3, CTRL.en=1 -> mtime increments once every 4 cycles; after 40 cycles MTIME_LO=10. Rewrite PRESCALE=0 -> +1 per cycle.
- Carry and wrap: write MTIME_HI=0xFFFF_FFFF, MTIME_LO=0xFFFF_FFFE, PRESCALE=0, enable -> after 2 ticks mtime=0. MTIME_LO write coincident with a tick -> written value read back.
- One-shot: ch0 CMP=100, en=1, INTR_ENABLE[0]=1 -> INTR_STATE[0] set when mtime reaches 100; timer_intr_o[0]/any_o high the next cycle; CH_CTRL.en reads 0; W1C clears the interrupt and it stays clear.
- Periodic, multi-channel: ch1 CMP=50, PERIOD=25, periodic; ch2 CMP=50, one-shot -> both set at mtime 50; ch1 CMP reads 75, then 100. W1C in the same cycle as a ch1 re-match -> bit remains 1.
- Errors and byte enables: read offset 0x01C and channel NrChannels -> err=1, rdata=0. Write PERIOD with be=4'b0010, wdata=0xAABBCCDD -> PERIOD=0x0000CC00.

Source files
------------

// File: rtl/timer_multi_ch.sv
// Multi-channel bus timer: one prescaled 64-bit mtime counter shared by
// NrChannels 64-bit comparators with one-shot or auto-reload behaviour.
module timer_multi_ch #(
   parameter int unsigned NrChannels    = 4,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned AddressWidth  = 32,
   parameter int unsigned PrescaleWidth = 12
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    timer_req_i,
   input  logic                    timer_we_i,
   input  logic [3:0]              timer_be_i,
   input  logic [AddressWidth-1:0] timer_addr_i,
   input  logic [DataWidth-1:0]    timer_wdata_i,
   output logic                    timer_rvalid_o,
   output logic [DataWidth-1:0]    timer_rdata_o,
   output logic                    timer_err_o,
   output logic [NrChannels-1:0]   timer_intr_o,
   output logic                    timer_intr_any_o
);

   localparam int unsigned N = NrChannels;

   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return res;
   endfunction

   logic                     ctrl_en_q, ctrl_en_d;
   logic [PrescaleWidth-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
   logic [63:0]              mtime_q, mtime_d;
   logic [N-1:0]             intr_state_q, intr_state_d, intr_enable_q, intr_enable_d;
   logic [N-1:0]             ch_en_q, ch_en_d, ch_per_q, ch_per_d;
   logic [N-1:0][63:0]       cmp_q, cmp_d;
   logic [N-1:0][31:0]       period_q, period_d;
   logic [N-1:0]             intr_q, intr_d;
   logic                     intr_any_q, intr_any_d;
   logic                     rvalid_q, rvalid_d, err_q, err_d;
   logic [DataWidth-1:0]     rdata_q, rdata_d;

   logic [N-1:0] match;
   logic         tick;
   logic [7:0]   widx;
   logic [3:0]   ch_idx;
   logic [1:0]   ch_reg;
   logic         glb_sel, ch_sel, addr_ok, wr_en, rd_en;
   logic [31:0]  wmerge;
   logic         unused_addr;

   // Only the word index inside the 1 kB window is decoded.
   assign widx        = timer_addr_i[9:2];
   assign unused_addr = ^{timer_addr_i[AddressWidth-1:10], timer_addr_i[1:0]};
   assign glb_sel     = (widx[7:6] == 2'b00);
   assign ch_sel      = (widx[7:6] == 2'b01);
   assign ch_idx      = widx[5:2];
   assign ch_reg      = widx[1:0];
   assign addr_ok     = glb_sel ? (widx[5:0] <= 6'd5) : (ch_sel && (32'(ch_idx) < N));
   assign wr_en       = timer_req_i && timer_we_i && addr_ok;
   assign rd_en       = timer_req_i && !timer_we_i && addr_ok;

   always_comb begin
      for (int n = 0; n < N; n++) match[n] = ch_en_q[n] && (mtime_q >= cmp_q[n]);
   end

   always_comb begin
      ctrl_en_d     = ctrl_en_q;
      prescale_d    = prescale_q;
      pcnt_d        = pcnt_q;
      mtime_d       = mtime_q;
      intr_enable_d = intr_enable_q;
      intr_state_d  = intr_state_q;
      cmp_d         = cmp_q;
      ch_en_d       = ch_en_q;
      ch_per_d      = ch_per_q;
      period_d      = period_q;
      tick          = 1'b0;
      wmerge        = '0;

      if (ctrl_en_q) begin
         if (pcnt_q == prescale_q) begin
            pcnt_d = '0;
            tick   = 1'b1;
         end else begin
            pcnt_d = pcnt_q + PrescaleWidth'(1);
         end
      end
      if (tick) mtime_d = mtime_q + 64'd1;

      // Hardware channel updates first; bus writes below override them.
      for (int n = 0; n < N; n++) begin
         if (match[n]) begin
            if (ch_per_q[n]) cmp_d[n] = cmp_q[n] + {32'd0, period_q[n]};
            else             ch_en_d[n] = 1'b0;
         end
      end

      if (wr_en && glb_sel) begin
         case (widx[5:0])
            6'd0: begin
               wmerge    = be_merge({31'd0, ctrl_en_q}, timer_wdata_i, timer_be_i);
               ctrl_en_d = wmerge[0];
            end
            6'd1: begin
               wmerge     = be_merge(32'(prescale_q), timer_wdata_i, timer_be_i);
               prescale_d = wmerge[PrescaleWidth-1:0];
               pcnt_d     = '0;
            end
            6'd2: mtime_d = {mtime_q[63:32], be_merge(mtime_q[31:0], timer_wdata_i, timer_be_i)};
            6'd3: mtime_d = {be_merge(mtime_q[63:32], timer_wdata_i, timer_be_i), mtime_q[31:0]};
            6'd4: begin
               wmerge       = be_merge(32'd0, timer_wdata_i, timer_be_i);
               intr_state_d = intr_state_q & ~wmerge[N-1:0];
            end
            6'd5: begin
               wmerge        = be_merge(32'(intr_enable_q), timer_wdata_i, timer_be_i);
               intr_enable_d = wmerge[N-1:0];
            end
            default: ;
         endcase
      end

      // A match sets its state bit even against a simultaneous W1C.
      intr_state_d = intr_state_d | match;

      for (int n = 0; n < N; n++) begin
         if (wr_en && ch_sel && (ch_idx == 4'(n))) begin
            case (ch_reg)
               2'd0: cmp_d[n] = {cmp_q[n][63:32], be_merge(cmp_q[n][31:0], timer_wdata_i, timer_be_i)};
               2'd1: cmp_d[n] = {be_merge(cmp_q[n][63:32], timer_wdata_i, timer_be_i), cmp_q[n][31:0]};
               2'd2: begin
                  wmerge      = be_merge({30'd0, ch_per_q[n], ch_en_q[n]}, timer_wdata_i, timer_be_i);
                  ch_en_d[n]  = wmerge[0];
                  ch_per_d[n] = wmerge[1];
               end
               default: period_d[n] = be_merge(period_q[n], timer_wdata_i, timer_be_i);
            endcase
         end
      end
   end

   always_comb begin
      rdata_d    = '0;
      rvalid_d   = timer_req_i;
      err_d      = timer_req_i && !addr_ok;
      intr_d     = intr_state_q & intr_enable_q;
      intr_any_d = |(intr_state_q & intr_enable_q);
      if (rd_en && glb_sel) begin
         case (widx[5:0])
            6'd0:    rdata_d = {31'd0, ctrl_en_q};
            6'd1:    rdata_d = 32'(prescale_q);
            6'd2:    rdata_d = mtime_q[31:0];
            6'd3:    rdata_d = mtime_q[63:32];
            6'd4:    rdata_d = 32'(intr_state_q);
            6'd5:    rdata_d = 32'(intr_enable_q);
            default: rdata_d = '0;
         endcase
      end else if (rd_en) begin
         for (int n = 0; n < N; n++) begin
            if (ch_idx == 4'(n)) begin
               case (ch_reg)
                  2'd0:    rdata_d = cmp_q[n][31:0];
                  2'd1:    rdata_d = cmp_q[n][63:32];
                  2'd2:    rdata_d = {30'd0, ch_per_q[n], ch_en_q[n]};
                  default: rdata_d = period_q[n];
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ctrl_en_q     <= 1'b0;
         prescale_q    <= '0;
         pcnt_q        <= '0;
         mtime_q       <= '0;
         intr_state_q  <= '0;
         intr_enable_q <= '0;
         cmp_q         <= '0;
         ch_en_q       <= '0;
         ch_per_q      <= '0;
         period_q      <= '0;
         intr_q        <= '0;
         intr_any_q    <= 1'b0;
         rvalid_q      <= 1'b0;
         err_q         <= 1'b0;
         rdata_q       <= '0;
      end else begin
         ctrl_en_q     <= ctrl_en_d;
         prescale_q    <= prescale_d;
         pcnt_q        <= pcnt_d;
         mtime_q       <= mtime_d;
         intr_state_q  <= intr_state_d;
         intr_enable_q <= intr_enable_d;
         cmp_q         <= cmp_d;
         ch_en_q       <= ch_en_d;
         ch_per_q      <= ch_per_d;
         period_q      <= period_d;
         intr_q        <= intr_d;
         intr_any_q    <= intr_any_d;
         rvalid_q      <= rvalid_d;
         err_q         <= err_d;
         rdata_q       <= rdata_d;
      end
   end

   assign timer_rvalid_o   = rvalid_q;
   assign timer_rdata_o    = rdata_q;
   assign timer_err_o      = err_q;
   assign timer_intr_o     = intr_q;
   assign timer_intr_any_o = intr_any_q;

endmodule

// File: tb/tb_timer_multi_ch.sv
// Self-checking bench for timer_multi_ch: bus expectations are queued at
// issue time and compared when the response arrives.
module tb_timer_multi_ch;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        timer_req_i = 1'b0;
   logic        timer_we_i = 1'b0;
   logic [3:0]  timer_be_i = 4'h0;
   logic [31:0] timer_addr_i = '0;
   logic [31:0] timer_wdata_i = '0;
   logic        timer_rvalid_o;
   logic [31:0] timer_rdata_o;
   logic        timer_err_o;
   logic [3:0]  timer_intr_o;
   logic        timer_intr_any_o;

   timer_multi_ch #(.NrChannels(4), .DataWidth(32), .AddressWidth(32), .PrescaleWidth(12)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .timer_req_i(timer_req_i), .timer_we_i(timer_we_i), .timer_be_i(timer_be_i),
      .timer_addr_i(timer_addr_i), .timer_wdata_i(timer_wdata_i),
      .timer_rvalid_o(timer_rvalid_o), .timer_rdata_o(timer_rdata_o), .timer_err_o(timer_err_o),
      .timer_intr_o(timer_intr_o), .timer_intr_any_o(timer_intr_any_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      bit          cd;
      longint      due;
   } exp_t;

   exp_t   q[$];
   exp_t   e;
   longint cyc = 0;
   int     n_chk = 0;
   int     n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   // Every queued request must be answered on the cycle after it was sampled.
   always @(negedge clk_i) begin
      if (timer_rvalid_o) begin
         if (q.size() == 0 || q[0].due != cyc) begin
            chk("spurious_rvalid", 64'd1, 64'd0);
         end else begin
            e = q.pop_front();
            if (e.cd) chk(e.tag, 64'(timer_rdata_o), 64'(e.rdata));
            chk({e.tag, "_err"}, 64'(timer_err_o), 64'(e.err));
         end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         chk({e.tag, "_rvalid"}, 64'd0, 64'd1);
      end
   end

   task automatic bus(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [31:0] exp, input bit exp_err, input string tag);
      exp_t x;
      @(negedge clk_i);
      timer_req_i = 1'b1; timer_we_i = we; timer_addr_i = a; timer_wdata_i = d; timer_be_i = be;
      x.tag = tag; x.rdata = exp; x.err = exp_err; x.cd = !we; x.due = cyc + 1;
      q.push_back(x);
      @(negedge clk_i);
      timer_req_i = 1'b0; timer_we_i = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus(1'b1, a, d, 4'hF, 32'd0, 1'b0, "wr");
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      bus(1'b0, a, 32'd0, 4'h0, exp, 1'b0, tag);
   endtask

   logic [31:0] zaddr [14] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014, 32'h100,
                               32'h104, 32'h108, 32'h10C, 32'h110, 32'h118, 32'h11C, 32'h120};

   initial begin
      repeat (3) @(negedge clk_i);
      chk("rst_rvalid", 64'(timer_rvalid_o), 64'd0);
      chk("rst_intr", 64'(timer_intr_o), 64'd0);
      chk("rst_any", 64'(timer_intr_any_o), 64'd0);
      rst_ni = 1'b1;

      // Prescaler: divide-by-4 over 40 enabled cycles, then divide-by-1 over 20.
      wr(32'h004, 32'd3);
      wr(32'h000, 32'd1);
      repeat (38) @(negedge clk_i);
      wr(32'h000, 32'd0);
      rd(32'h008, 32'd10, "mtime_div4");
      wr(32'h004, 32'd0);
      wr(32'h000, 32'd1);
      repeat (18) @(negedge clk_i);
      wr(32'h000, 32'd0);
      rd(32'h008, 32'd30, "mtime_div1");
      rd(32'h004, 32'd0, "prescale_rd");

      // 64-bit carry and wrap over two ticks.
      wr(32'h00C, 32'hFFFF_FFFF);
      wr(32'h008, 32'hFFFF_FFFE);
      wr(32'h000, 32'd1);
      wr(32'h000, 32'd0);
      rd(32'h008, 32'd0, "wrap_lo");
      rd(32'h00C, 32'd0, "wrap_hi");

      // MTIME_LO write lands on a tick cycle; two more ticks follow it.
      wr(32'h000, 32'd1);
      wr(32'h008, 32'h1234);
      wr(32'h000, 32'd0);
      rd(32'h008, 32'h1236, "mtime_wr_wins");
      rd(32'h00C, 32'd0, "mtime_hi_nocarry");

      // One-shot on ch0 with mtime frozen; the match comes from the MTIME write.
      wr(32'h008, 32'd0);
      wr(32'h100, 32'd100);
      wr(32'h104, 32'd0);
      wr(32'h014, 32'd1);
      wr(32'h108, 32'd1);
      wr(32'h008, 32'd100);
      @(negedge clk_i);
      chk("intr_early", 64'(timer_intr_o), 64'd0);
      @(negedge clk_i);
      chk("intr_oneshot", 64'(timer_intr_o), 64'd1);
      chk("any_oneshot", 64'(timer_intr_any_o), 64'd1);
      rd(32'h108, 32'd0, "oneshot_en_clr");
      rd(32'h010, 32'd1, "oneshot_state");
      rd(32'h100, 32'd100, "oneshot_cmp_kept");
      wr(32'h010, 32'd1);
      rd(32'h010, 32'd0, "w1c_clear");
      rd(32'h010, 32'd0, "w1c_stays");
      chk("intr_cleared", 64'(timer_intr_o), 64'd0);

      // ch1 periodic, ch2 one-shot, both at 50.
      wr(32'h008, 32'd40);
      wr(32'h110, 32'd50);
      wr(32'h11C, 32'd25);
      wr(32'h118, 32'd3);
      wr(32'h120, 32'd50);
      wr(32'h128, 32'd1);
      wr(32'h014, 32'h6);
      rd(32'h010, 32'd0, "no_match_early");
      wr(32'h008, 32'd50);
      rd(32'h010, 32'h6, "both_match");
      rd(32'h110, 32'd75, "ch1_reload1");
      rd(32'h114, 32'd0, "ch1_cmp_hi");
      rd(32'h128, 32'd0, "ch2_en_clr");
      rd(32'h118, 32'd3, "ch1_ctrl_kept");
      chk("intr_multi", 64'(timer_intr_o), 64'h6);
      wr(32'h008, 32'd75);
      rd(32'h110, 32'd100, "ch1_reload2");

      // PERIOD=0 keeps ch1 matching every cycle, so its W1C loses.
      wr(32'h11C, 32'd0);
      wr(32'h008, 32'd100);
      wr(32'h010, 32'h2);
      rd(32'h010, 32'h6, "w1c_vs_set");
      wr(32'h010, 32'h4);
      rd(32'h010, 32'h2, "w1c_ch2");
      rd(32'h110, 32'd100, "ch1_period0_cmp");
      wr(32'h118, 32'd0);
      wr(32'h010, 32'h2);
      rd(32'h010, 32'd0, "w1c_after_dis");

      // Error decode and byte enables.
      bus(1'b0, 32'h01C, 32'd0, 4'h0, 32'd0, 1'b1, "err_01c");
      bus(1'b0, 32'h018, 32'd0, 4'h0, 32'd0, 1'b1, "err_018");
      bus(1'b0, 32'h140, 32'd0, 4'h0, 32'd0, 1'b1, "err_ch4");
      bus(1'b0, 32'h200, 32'd0, 4'h0, 32'd0, 1'b1, "err_200");
      bus(1'b1, 32'h014, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0, "wr_ien_wide");
      rd(32'h014, 32'hF, "ien_unused_bits");
      bus(1'b1, 32'h10C, 32'hAABB_CCDD, 4'b0010, 32'd0, 1'b0, "wr_be");
      rd(32'h10C, 32'h0000_CC00, "period_be");
      rd(32'h000, 32'd0, "ctrl_before_err_wr");
      bus(1'b1, 32'h01C, 32'd1, 4'hF, 32'd0, 1'b1, "err_wr");
      rd(32'h104, 32'd0, "cmp_hi_rd");

      // Reset lands on the cycle a read is sampled: that read must never answer.
      wr(32'h004, 32'd5);
      wr(32'h000, 32'd1);
      @(negedge clk_i);
      timer_req_i = 1'b1; timer_we_i = 1'b0; timer_addr_i = 32'h014; rst_ni = 1'b0;
      @(negedge clk_i);
      timer_req_i = 1'b0;
      chk("rst_drop_rvalid", 64'(timer_rvalid_o), 64'd0);
      @(negedge clk_i);
      chk("rst_drop_rvalid2", 64'(timer_rvalid_o), 64'd0);
      rst_ni = 1'b1;
      foreach (zaddr[i]) rd(zaddr[i], 32'd0, $sformatf("rst_zero_%0h", zaddr[i]));
      chk("rst_intr_after", 64'(timer_intr_o), 64'd0);

      repeat (3) @(negedge clk_i);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
